multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/mips_pkg.sv | 71 +++++++
 rtl/mc_aludec.sv | 40 ++++
 rtl/multicycle_controller.sv | 168 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller.
//   - FSM state enum, control-word struct
//   - opcode / funct field encodings
//   - ALU operation class (aluop) and ALU control codes
//   - is_known_op(): opcodes the controller dispatches on
// Optional feature: define MC_BNE_EN to add bne (op 000101) to the decoder.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
  } state_t;

  typedef logic [1:0] aluop_t;

  localparam aluop_t ALUOP_ADD   = 2'b00;
  localparam aluop_t ALUOP_SUB   = 2'b01;
  localparam aluop_t ALUOP_FUNCT = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Control word held in a register alongside the state.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       membyteread;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       bne;
    aluop_t     aluop;
  } ctrl_t;

  function automatic logic is_known_op(logic [5:0] op);
    logic known;
    case (op)
      OP_LW, OP_SW, OP_LBU, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: known = 1'b1;
`ifdef MC_BNE_EN
      OP_BNE: known = 1'b1;
`endif
      default: known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder (combinational).
// Ports:
//   aluop      in  2          operation class from the controller FSM
//   funct      in  FUNCT_W    R-type function field
//   alucontrol out ALUCTRL_W  ALU operation code, zero-extended
module mc_aludec
  import mips_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int FUNCT_W   = 6
) (
  input  aluop_t               aluop,
  input  logic [FUNCT_W-1:0]   funct,
  output logic [ALUCTRL_W-1:0] alucontrol
);

  logic [2:0] code;

  always_comb begin
    code = ALU_ADD;
    case (aluop)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_W'(F_ADD): code = ALU_ADD;
          FUNCT_W'(F_SUB): code = ALU_SUB;
          FUNCT_W'(F_AND): code = ALU_AND;
          FUNCT_W'(F_OR):  code = ALU_OR;
          FUNCT_W'(F_SLT): code = ALU_SLT;
          default:         code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alucontrol = ALUCTRL_W'(code);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS controller: Moore FSM sequencing fetch/decode/execute
// with a registered control word, plus the ALU decoder and PC-enable logic.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   op, funct, zero       opcode, R-type funct, ALU zero flag
//   iord .. pcsrc         datapath mux selects and write strobes
//   pcen                  pcwrite | taken branch (only zero-dependent output)
//   alucontrol            ALU operation
//   illegal_op            high during DECODE of an unknown opcode
// Optional feature: `define MC_BNE_EN adds bne, executed in BEQEX with the
// branch condition inverted.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int FUNCT_W   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 zero,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 membyteread,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal_op
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;
  logic   branch_taken;

  function automatic state_t next_of(state_t s, logic [5:0] o);
    state_t n;
    case (s)
      FETCH:  n = DECODE;
      DECODE: begin
        case (o)
          OP_LW, OP_SW, OP_LBU: n = MEMADR;
          OP_RTYPE:             n = RTYPEEX;
          OP_BEQ:               n = BEQEX;
`ifdef MC_BNE_EN
          OP_BNE:               n = BEQEX;
`endif
          OP_ADDI:              n = ADDIEX;
          OP_J:                 n = JEX;
          default:              n = FETCH;
        endcase
      end
      MEMADR:  n = (o == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   n = MEMWB;
      RTYPEEX: n = RTYPEWB;
      ADDIEX:  n = ADDIWB;
      default: n = FETCH;
    endcase
    return n;
  endfunction

  // Control word of a state; op only matters for the lbu/bne qualifiers,
  // which are captured when the state is entered.
  function automatic ctrl_t ctrl_of(state_t s, logic [5:0] o);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = 2'b01;
      end
      DECODE: c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD: begin
        c.iord        = 1'b1;
        c.membyteread = (o == OP_LBU);
      end
      MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BEQEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.branch  = 1'b1;
        c.pcsrc   = 2'b01;
`ifdef MC_BNE_EN
        c.bne     = (o == OP_BNE);
`endif
      end
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ADDIWB: c.regwrite = 1'b1;
      JEX: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign state_nxt = next_of(state, op);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ctrl  <= ctrl_of(FETCH, op);
    end else begin
      state <= state_nxt;
      ctrl  <= ctrl_of(state_nxt, op);
    end
  end

  mc_aludec #(
    .ALUCTRL_W(ALUCTRL_W),
    .FUNCT_W  (FUNCT_W)
  ) u_aludec (
    .aluop     (ctrl.aluop),
    .funct     (funct),
    .alucontrol(alucontrol)
  );

  // bne shares BEQEX; the captured bne flag flips the zero sense.
  assign branch_taken = ctrl.branch & (ctrl.bne ? ~zero : zero);

  // Strobes that change architectural state are held off while reset is
  // asserted, since the registered control word only updates on the edge.
  assign pcen        = (ctrl.pcwrite | branch_taken) & ~reset;
  assign irwrite     = ctrl.irwrite  & ~reset;
  assign memwrite    = ctrl.memwrite & ~reset;
  assign regwrite    = ctrl.regwrite & ~reset;
  assign illegal_op  = (state == DECODE) & ~is_known_op(op) & ~reset;

  assign iord        = ctrl.iord;
  assign membyteread = ctrl.membyteread;
  assign regdst      = ctrl.regdst;
  assign memtoreg    = ctrl.memtoreg;
  assign alusrca     = ctrl.alusrca;
  assign alusrcb     = ctrl.alusrcb;
  assign pcsrc       = ctrl.pcsrc;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is run
// cycle by cycle against a reference model that derives the expected
// outputs from the instruction class and the cycle index within it.
module tb_multicycle_controller;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, LBU = 6'b100100;
  localparam logic [5:0] RT = 6'b000000, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010;
`ifdef MC_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       membyteread;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       illegal_op;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       iord, memwrite, membyteread, irwrite, regdst, memtoreg;
  logic       regwrite, alusrca, pcen, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  int checks = 0;
  int failures = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .membyteread(membyteread),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic obs_t sample();
    obs_t s;
    s = '{iord, memwrite, membyteread, irwrite, regdst, memtoreg, regwrite,
          alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op};
    return s;
  endfunction

  function automatic logic [2:0] ref_alu(logic [5:0] f);
    case (f)
      6'd32: return 3'd2;
      6'd34: return 3'd6;
      6'd36: return 3'd0;
      6'd37: return 3'd1;
      6'd42: return 3'd7;
      default: return 3'd2;
    endcase
  endfunction

  function automatic bit is_branch(logic [5:0] o);
    return (o == BEQ) || (BNE_EN && o == BNE);
  endfunction

  function automatic int latency(logic [5:0] o);
    if (o == LW || o == LBU) return 5;
    if (o == SW || o == RT || o == ADDI) return 4;
    if (is_branch(o) || o == JMP) return 3;
    return 2;
  endfunction

  // Expected outputs in cycle k of an instruction (k=0 is its fetch).
  function automatic obs_t model(logic [5:0] o, logic [5:0] f, logic z, int k);
    obs_t e;
    bit   load;
    e = '0;
    e.alucontrol = 3'd2;
    load = (o == LW) || (o == LBU);
    case (k)
      0: begin e.irwrite = 1; e.alusrcb = 2'b01; e.pcen = 1; end
      1: begin e.alusrcb = 2'b11; e.illegal_op = (latency(o) == 2); end
      2: begin
        if (load || o == SW || o == ADDI) begin e.alusrca = 1; e.alusrcb = 2'b10; end
        else if (o == RT) begin e.alusrca = 1; e.alucontrol = ref_alu(f); end
        else if (is_branch(o)) begin
          e.alusrca = 1; e.alucontrol = 3'd6; e.pcsrc = 2'b01;
          e.pcen = (o == BNE) ? ~z : z;
        end
        else if (o == JMP) begin e.pcsrc = 2'b10; e.pcen = 1; end
      end
      3: begin
        if (load) begin e.iord = 1; e.membyteread = (o == LBU); end
        else if (o == SW) begin e.iord = 1; e.memwrite = 1; end
        else if (o == RT) begin e.regdst = 1; e.regwrite = 1; end
        else if (o == ADDI) e.regwrite = 1;
      end
      4: if (load) begin e.regwrite = 1; e.memtoreg = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Runs one instruction starting at the current FETCH cycle. ncyc<0 runs
  // the full expected latency; zsel<0 randomizes zero every cycle.
  task automatic exec_instr(input string name, input logic [5:0] o,
                            input logic [5:0] f, input int zsel, input int ncyc);
    obs_t got, exp;
    int n;
    n = (ncyc < 0) ? latency(o) : ncyc;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) begin op = o; funct = f; end
      zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      #1;
      got = sample();
      exp = model(o, f, zero, k);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s k=%0d op=%b funct=%b zero=%b got=%h want=%h",
                 name, k, o, f, zero, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({irwrite, pcen, memwrite, regwrite, illegal_op} !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=00000",
               {irwrite, pcen, memwrite, regwrite, illegal_op});
    end
    @(posedge clk); #1;
    reset = 0; #1;
    checks++;
    if ({irwrite, pcen} !== 2'b11) begin
      failures++;
      $display("FAIL reset_release_fetch got=%b want=11", {irwrite, pcen});
    end
  endtask

  task automatic test_lw();
    exec_instr("lw", LW, 6'($urandom), -1, -1);
    exec_instr("lbu", LBU, 6'($urandom), -1, -1);
    exec_instr("sw", SW, 6'($urandom), -1, -1);
    exec_instr("addi", ADDI, 6'($urandom), -1, -1);
    exec_instr("j", JMP, 6'($urandom), -1, -1);
  endtask

  task automatic test_rtype();
    logic [5:0] fl [6];
    fl = '{6'd42, 6'd32, 6'd34, 6'd36, 6'd37, 6'd0};
    for (int i = 0; i < 6; i++) exec_instr("rtype", RT, fl[i], -1, -1);
    exec_instr("rtype_rand", RT, 6'($urandom), -1, -1);
  endtask

  task automatic test_beq();
    exec_instr("beq_z1", BEQ, 6'd0, 1, -1);
    exec_instr("beq_z0", BEQ, 6'd0, 0, -1);
    exec_instr("beq_rand", BEQ, 6'd0, -1, -1);
  endtask

  task automatic test_illegal();
    exec_instr("illegal_ff", 6'b111111, 6'd0, -1, -1);
    exec_instr("illegal_ff_again", 6'b111111, 6'd0, -1, -1);
    exec_instr("illegal_rand", 6'b110011, 6'd0, -1, -1);
  endtask

  task automatic test_bne();
    exec_instr("bne_z0", BNE, 6'd0, 0, -1);
    exec_instr("bne_z1", BNE, 6'd0, 1, -1);
  endtask

  task automatic test_reset_mid();
    logic [5:0] ol [2];
    ol = '{LW, SW};
    for (int i = 0; i < 2; i++) begin
      exec_instr("mid_prefix", ol[i], 6'd0, -1, 4);
      reset = 1; #1;
      checks++;
      if ({irwrite, pcen, memwrite, regwrite, illegal_op} !== 5'b0) begin
        failures++;
        $display("FAIL mid_reset_strobes op=%b got=%b want=00000", ol[i],
                 {irwrite, pcen, memwrite, regwrite, illegal_op});
      end
      @(posedge clk); #1;
      reset = 0; #1;
      checks++;
      if (irwrite !== 1'b1) begin
        failures++;
        $display("FAIL mid_reset_fetch op=%b irwrite got=%b want=1", ol[i], irwrite);
      end
      exec_instr("after_mid_reset", JMP, 6'd0, -1, -1);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ol [8];
    logic [5:0] fl [5];
    logic [5:0] o, f;
    ol = '{LW, SW, LBU, RT, BEQ, ADDI, JMP, BNE};
    fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    for (int i = 0; i < 60; i++) begin
      o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ol[$urandom_range(0, 7)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 4)];
      exec_instr("random", o, f, -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_illegal();
    test_bne();
    test_reset_mid();
    test_back_to_back();
    exec_instr("final_fetch", JMP, 6'd0, -1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
